// File: rtl/memr_pkg.sv
// Shared constants and FSM state type for the R-vector memory write path.
package memr_pkg;

  localparam int ELEMENT_WIDTH = 64;
  localparam int NO_OF_UNITS   = 8;
  localparam int ADDRESS_WIDTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } memr_state_e;

endpackage

// File: rtl/memr_stream_writer_if.sv
// Element stream in, memory write port out, grouped for the stream writer.
interface memr_stream_writer_if
  import memr_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS,
  parameter int address_width = ADDRESS_WIDTH
) ();

  // An element transfers on a rising edge where in_valid && in_ready; the
  // producer holds in_data stable while in_valid waits for in_ready.
  logic                                 in_valid;
  logic [element_width-1:0]             in_data;
  logic                                 in_ready;
  logic                                 mem_write_enable;
  logic [address_width-1:0]             mem_write_address;
  logic [no_of_units*element_width-1:0] mem_write_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_write_enable, mem_write_address, mem_write_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_write_enable, mem_write_address, mem_write_data
  );

endinterface

// File: rtl/memr_lane_packer.sv
// Collects consecutive elements into lanes; packed_next already includes the element loaded this cycle.
module memr_lane_packer
  import memr_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [element_width-1:0]             in_data,
  output logic [no_of_units*element_width-1:0] packed_next,
  output logic                                 last_lane
);

  localparam int LW = (no_of_units > 1) ? $clog2(no_of_units) : 1;

  logic [element_width-1:0] lanes_q [no_of_units];
  logic [element_width-1:0] lanes_d [no_of_units];
  logic [LW-1:0]            lane_cnt_q, lane_cnt_d;

  assign last_lane = (lane_cnt_q == LW'(no_of_units - 1));

  always_comb begin
    lanes_d    = lanes_q;
    lane_cnt_d = lane_cnt_q;
    if (clear) begin
      lane_cnt_d = '0;
    end else if (load) begin
      lanes_d[lane_cnt_q] = in_data;
      lane_cnt_d          = last_lane ? '0 : lane_cnt_q + LW'(1);
    end
  end

  always_comb begin
    packed_next = '0;
    for (int i = 0; i < no_of_units; i++) begin
      packed_next[i*element_width +: element_width] = lanes_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < no_of_units; i++) lanes_q[i] <= '0;
      lane_cnt_q <= '0;
    end else begin
      lanes_q    <= lanes_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

endmodule

// File: rtl/memr_stream_writer.sv
// Packs the element stream into memory words and writes word_count words from base_address on.
module memr_stream_writer
  import memr_pkg::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS,
  parameter int address_width = ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [address_width-1:0] base_address,
  input  logic [address_width-1:0] word_count,
  output logic                     busy,
  output logic                     finish,
  output memr_state_e              dbg_state,
  memr_stream_writer_if.slave      bus
);

  localparam int DW = no_of_units * element_width;

  memr_state_e              state_q, state_d;
  logic [address_width-1:0] base_q, base_d;
  logic [address_width-1:0] count_q, count_d;
  logic [address_width-1:0] word_idx_q, word_idx_d;
  logic                     in_ready_q, in_ready_d;
  logic                     we_q, we_d;
  logic [address_width-1:0] addr_q, addr_d;
  logic [DW-1:0]            data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     finish_q, finish_d;

  logic          pack_clear;
  logic          accept;
  logic          last_lane;
  logic [DW-1:0] packed_next;

  assign accept = in_ready_q && bus.in_valid;

  memr_lane_packer #(
    .element_width(element_width),
    .no_of_units  (no_of_units)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .load       (accept),
    .in_data    (bus.in_data),
    .packed_next(packed_next),
    .last_lane  (last_lane)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    pack_clear = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          base_d     = base_address;
          count_d    = word_count;
          word_idx_d = '0;
          pack_clear = 1'b1;
          state_d    = (word_count == '0) ? ST_DONE : ST_PACK;
        end
      end
      ST_PACK: begin
        if (accept && last_lane) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + address_width'(1);
        state_d    = (word_idx_d == count_q) ? ST_DONE : ST_PACK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    in_ready_d = (state_d == ST_PACK);
    we_d       = (state_d == ST_WRITE);
    busy_d     = in_ready_d || we_d;
    finish_d   = (state_d == ST_DONE);
    addr_d     = addr_q;
    data_d     = data_q;
    if (state_q == ST_PACK && state_d == ST_WRITE) begin
      addr_d = base_q + word_idx_q;
      data_d = packed_next;
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.mem_write_enable  = we_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = data_q;
  assign busy                  = busy_q;
  assign finish                = finish_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_memr_stream_writer.sv
// Directed bench for memr_stream_writer: table of transfer runs plus reset and ignored-start sequences.
module tb_memr_stream_writer;
  import memr_pkg::*;

  localparam int EW = ELEMENT_WIDTH;
  localparam int NU = NO_OF_UNITS;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = EW * NU;
  localparam int SW = AW + DW;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] count;
    bit            gaps;
    logic [EW-1:0] first;
    logic [AW-1:0] exp_addr [3];
  } run_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] word_count;
  logic          busy;
  logic          finish;
  memr_state_e   dbg_state;

  logic [SW-1:0] exp_q [$];
  run_t          runs [5];
  int            n_checks;
  int            n_fail;
  int            n_writes;
  int            cyc;
  int            start_cyc;

  memr_stream_writer_if #(.element_width(EW), .no_of_units(NU), .address_width(AW)) bus ();

  memr_stream_writer #(.element_width(EW), .no_of_units(NU), .address_width(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_address(base_address),
    .word_count  (word_count),
    .busy        (busy),
    .finish      (finish),
    .dbg_state   (dbg_state),
    .bus         (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    n_checks = n_checks + 1;
    n_fail   = n_fail + 1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_word(input logic [EW-1:0] first);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < NU; i++) w[i*EW +: EW] = first + EW'(i);
    return w;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.mem_write_enable) begin
      n_writes = n_writes + 1;
      check("in_ready_in_write", SW'(bus.in_ready), SW'(0));
      check("busy_in_write", SW'(busy), SW'(1));
      if (exp_q.size() == 0) begin
        n_checks = n_checks + 1;
        n_fail   = n_fail + 1;
        $display("FAIL unexpected_write actual_addr=%0h required=no write", bus.mem_write_address);
      end else begin
        check("write_addr_data", {bus.mem_write_address, bus.mem_write_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers (called and returning at a negedge) ----------------
  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] c);
    start        = 1'b1;
    base_address = b;
    word_count   = c;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_elem(input logic [EW-1:0] v, input bit gaps);
    int budget;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    budget       = 50;
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL in_ready_timeout element=%0h", v);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_once(input run_t r);
    for (int w = 0; w < int'(r.count); w++)
      exp_q.push_back({r.exp_addr[w], pack_word(r.first + EW'(w * NU))});
    do_start(r.base, r.count);
    if (r.count == '0) begin
      check("zero_count_finish", SW'(finish), SW'(1));
      check("zero_count_busy", SW'(busy), SW'(0));
      check("zero_count_in_ready", SW'(bus.in_ready), SW'(0));
      repeat (3) @(negedge clk);
      check("zero_count_finish_held", SW'(finish), SW'(1));
    end else begin
      check("in_ready_after_start", SW'(bus.in_ready), SW'(1));
      check("finish_cleared_by_start", SW'(finish), SW'(0));
      for (int w = 0; w < int'(r.count); w++)
        for (int l = 0; l < NU; l++)
          send_elem(r.first + EW'(w * NU + l), r.gaps);
      check("last_write_cycle_we", SW'(bus.mem_write_enable), SW'(1));
      check("finish_low_in_write", SW'(finish), SW'(0));
      @(negedge clk);
      check("finish_after_last", SW'(finish), SW'(1));
      check("busy_after_last", SW'(busy), SW'(0));
      check("all_words_written", SW'(exp_q.size()), SW'(0));
      if (!r.gaps) check("finish_latency", SW'(cyc - start_cyc), SW'(int'(r.count) * (NU + 1)));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_writes = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    base_address = '0;
    word_count   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    runs[0] = '{20'h00000, 20'd1, 1'b0, 64'd1,                  '{20'h00000, 20'h00000, 20'h00000}};
    runs[1] = '{20'h00010, 20'd3, 1'b1, 64'd0,                  '{20'h00010, 20'h00011, 20'h00012}};
    runs[2] = '{20'hFFFFF, 20'd2, 1'b0, 64'hDEAD_BEEF_0000_0000, '{20'hFFFFF, 20'h00000, 20'h00000}};
    runs[3] = '{20'h00005, 20'd0, 1'b0, 64'd0,                  '{20'h00000, 20'h00000, 20'h00000}};
    runs[4] = '{20'h12345, 20'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, '{20'h12345, 20'h12346, 20'h00000}};

    repeat (2) @(negedge clk);
    check("reset_in_ready", SW'(bus.in_ready), SW'(0));
    check("reset_we", SW'(bus.mem_write_enable), SW'(0));
    check("reset_addr", SW'(bus.mem_write_address), SW'(0));
    check("reset_data", SW'(bus.mem_write_data), SW'(0));
    check("reset_busy", SW'(busy), SW'(0));
    check("reset_finish", SW'(finish), SW'(0));
    check("reset_state", SW'(dbg_state), SW'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_once(runs[i]);

    // start pulsed mid-PACK must not restart the transfer
    exp_q.push_back({20'h00020, pack_word(64'h70)});
    do_start(20'h00020, 20'd1);
    for (int l = 0; l < 3; l++) send_elem(64'h70 + EW'(l), 1'b0);
    start        = 1'b1;
    base_address = 20'h00300;
    word_count   = 20'd0;
    send_elem(64'h73, 1'b0);
    start = 1'b0;
    check("ignored_start_finish", SW'(finish), SW'(0));
    check("ignored_start_busy", SW'(busy), SW'(1));
    for (int l = 4; l < NU; l++) send_elem(64'h70 + EW'(l), 1'b0);
    @(negedge clk);
    check("ignored_start_done", SW'(finish), SW'(1));
    check("ignored_start_written", SW'(exp_q.size()), SW'(0));

    // reset after 5 elements of word 0: no write, outputs clear at once
    do_start(20'h00040, 20'd1);
    for (int l = 0; l < 5; l++) send_elem(64'h200 + EW'(l), 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", SW'(bus.in_ready), SW'(0));
    check("midreset_we", SW'(bus.mem_write_enable), SW'(0));
    check("midreset_addr", SW'(bus.mem_write_address), SW'(0));
    check("midreset_data", SW'(bus.mem_write_data), SW'(0));
    check("midreset_busy", SW'(busy), SW'(0));
    check("midreset_finish", SW'(finish), SW'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_state", SW'(dbg_state), SW'(ST_IDLE));
    exp_q.push_back({20'h00050, pack_word(64'h300)});
    do_start(20'h00050, 20'd1);
    for (int l = 0; l < NU; l++) send_elem(64'h300 + EW'(l), 1'b0);
    @(negedge clk);
    check("post_reset_finish", SW'(finish), SW'(1));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", SW'(exp_q.size()), SW'(0));
    check("total_writes", SW'(n_writes), SW'(10));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
